// File: rtl/stat_report_pkg.sv
// Shared types and constants for the statistics report generator.
//   state_t   : frame FSM states
//   ASC_*     : ASCII constants used in report lines
//   nib2asc() : 4-bit value to upper-case ASCII hex digit
package stat_report_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TOT,
        S_SEP,
        S_COR,
        S_ERR,
        S_EOL,
        S_NEXT
    } state_t;

    localparam logic [7:0] ASC_C     = 8'h43;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    // 0-9 map onto '0'..'9'; 10-15 onto 'A'..'F' ('A' - 10 = 8'h37)
    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

endpackage

// File: rtl/stat_report_mc_tick.sv
// Report period timer.
//   clk, rst : clock, asynchronous active-high reset
//   tick     : one-cycle pulse every CLK_FREQ/REPORT_FREQ cycles
module report_tick_gen #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned REPORT_FREQ = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned P  = CLK_FREQ / REPORT_FREQ;
    localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;

    logic [CW-1:0] cnt;

    // Free-running period counter, wraps at P-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CW'(P - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Direct decode of the counter register; high for the last cycle of each period
    assign tick = (cnt == CW'(P - 1));

endmodule

// File: rtl/stat_report_mc.sv
// Periodic ASCII statistics reporter for a UART transmitter.
// Each period the per-channel total/correct counters are snapshotted and one
// line per enabled channel is streamed: "C<i>:<total> <correct>\r\n".
// Optional macro STAT_REPORT_ERR_EN appends " E<total-correct>" before CR.
//   clk, rst       : clock, asynchronous active-high reset
//   total, correct : N_CH packed CNT_W-bit counters (channel i at [i*CNT_W +: CNT_W])
//   ch_en          : per-channel report enable
//   data, valid    : byte stream to the transmitter, transfer when valid & require
//   require        : transmitter ready
//   busy           : frame in progress
//   overrun        : sticky, a report tick arrived while a frame was running
module stat_report_mc
    import stat_report_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned REPORT_FREQ = 2,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*CNT_W-1:0] total,
    input  logic [N_CH*CNT_W-1:0] correct,
    input  logic [N_CH-1:0]       ch_en,
    output logic [7:0]            data,
    output logic                  valid,
    input  logic                  require,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned D    = CNT_W / 4;
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PW   = $clog2(D + 3);

    logic                             tick;
    state_t                           state, state_n;
    logic [PW-1:0]                    pos, pos_n;
    logic [CH_W-1:0]                  ch, ch_n;
    logic [7:0]                       data_n;
    logic                             adv;
    logic [N_CH-1:0][CNT_W-1:0]       tot_s, cor_s;
    logic [N_CH-1:0]                  en_s;
    logic [CH_W:0]                    pick_first, pick_after;

    report_tick_gen #(
        .CLK_FREQ    (CLK_FREQ),
        .REPORT_FREQ (REPORT_FREQ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Lowest enabled channel above cur (or lowest overall when any=1); MSB = found
    function automatic logic [CH_W:0] pick(input logic [N_CH-1:0] en,
                                           input logic [CH_W-1:0] cur,
                                           input logic            any);
        logic [CH_W:0] r;
        r = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (en[i] && (any || (CH_W'(i) > cur))) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

    // Hex digit idx (0 = least significant) of a counter word
    function automatic logic [7:0] hex_digit(input logic [CNT_W-1:0] w,
                                             input logic [PW-1:0]    idx);
        return nib2asc(4'(w >> {idx, 2'b00}));
    endfunction

    assign adv        = valid && require;
    assign pick_first = pick(ch_en, '0, 1'b1);
    assign pick_after = pick(en_s, ch, 1'b0);

`ifdef STAT_REPORT_ERR_EN
    logic [CNT_W-1:0] err_w;
    assign err_w = tot_s[ch] - cor_s[ch];
`endif

    // Next state and next output byte; the byte for the state being entered is
    // prepared here so it is on data the cycle after each transfer.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        ch_n    = ch;
        data_n  = data;

        case (state)
            S_IDLE: begin
                if (tick && pick_first[CH_W]) begin
                    state_n = S_HDR;
                    pos_n   = '0;
                    ch_n    = pick_first[CH_W-1:0];
                end
            end
            S_HDR: if (adv) begin
                if (pos == PW'(2)) begin state_n = S_TOT; pos_n = '0; end
                else               pos_n = pos + PW'(1);
            end
            S_TOT: if (adv) begin
                if (pos == PW'(D - 1)) begin state_n = S_SEP; pos_n = '0; end
                else                   pos_n = pos + PW'(1);
            end
            S_SEP: if (adv) begin
                state_n = S_COR;
                pos_n   = '0;
            end
            S_COR: if (adv) begin
                if (pos == PW'(D - 1)) begin
`ifdef STAT_REPORT_ERR_EN
                    state_n = S_ERR;
`else
                    state_n = S_EOL;
`endif
                    pos_n = '0;
                end else begin
                    pos_n = pos + PW'(1);
                end
            end
`ifdef STAT_REPORT_ERR_EN
            S_ERR: if (adv) begin
                if (pos == PW'(D + 1)) begin state_n = S_EOL; pos_n = '0; end
                else                   pos_n = pos + PW'(1);
            end
`endif
            S_EOL: if (adv) begin
                if (pos == '0) begin
                    pos_n = PW'(1);
                end else if (pick_after[CH_W]) begin
                    // LF accepted: channel selection folded in so lines stay gapless
                    state_n = S_HDR;
                    pos_n   = '0;
                    ch_n    = pick_after[CH_W-1:0];
                end else begin
                    state_n = S_IDLE;
                    pos_n   = '0;
                end
            end
            S_NEXT: begin
                pos_n = '0;
                if (pick_after[CH_W]) begin
                    state_n = S_HDR;
                    ch_n    = pick_after[CH_W-1:0];
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                pos_n   = '0;
            end
        endcase

        case (state_n)
            S_HDR:   data_n = (pos_n == '0)     ? ASC_C :
                              (pos_n == PW'(1)) ? nib2asc(4'(ch_n)) : ASC_COLON;
            S_TOT:   data_n = hex_digit(tot_s[ch], PW'(D - 1) - pos_n);
            S_SEP:   data_n = ASC_SPACE;
            S_COR:   data_n = hex_digit(cor_s[ch], PW'(D - 1) - pos_n);
`ifdef STAT_REPORT_ERR_EN
            S_ERR:   data_n = (pos_n == '0)     ? ASC_SPACE :
                              (pos_n == PW'(1)) ? ASC_E :
                              hex_digit(err_w, PW'(D + 1) - pos_n);
`endif
            S_EOL:   data_n = (pos_n == '0) ? ASC_CR : ASC_LF;
            default: data_n = data;
        endcase
    end

    // State, output and snapshot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pos     <= '0;
            ch      <= '0;
            data    <= 8'h00;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            tot_s   <= '0;
            cor_s   <= '0;
            en_s    <= '0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            ch    <= ch_n;
            data  <= data_n;
            valid <= (state_n != S_IDLE);
            busy  <= (state_n != S_IDLE);
            // A tick on the final LF edge still sees a non-idle state and is dropped
            if (tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            if (tick && (state == S_IDLE)) begin
                tot_s <= total;
                cor_s <= correct;
                en_s  <= ch_en;
            end
        end
    end

endmodule

// File: tb/tb_stat_report_mc.sv
// Scoreboard bench for stat_report_mc (CLK_FREQ=100, REPORT_FREQ=1, N_CH=2, CNT_W=8).
// Stimulus pushes expected bytes into a queue; a negedge monitor pops on each transfer.
module tb_stat_report_mc;

`ifdef STAT_REPORT_ERR_EN
    localparam int L = 14;
`else
    localparam int L = 10;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] total;
    logic [15:0] correct;
    logic [1:0]  ch_en;
    logic [7:0]  data;
    logic        valid;
    logic        require;
    logic        busy;
    logic        overrun;

    int          errors;
    int          checks;
    int          cyc;
    int          last_cyc;
    logic [7:0]  exp_q[$];
    logic        hold_v;
    logic [7:0]  hold_d;
    logic [7:0]  ev;

    stat_report_mc #(
        .CLK_FREQ    (100),
        .REPORT_FREQ (1),
        .N_CH        (2),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .total   (total),
        .correct (correct),
        .ch_en   (ch_en),
        .data    (data),
        .valid   (valid),
        .require (require),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release; matches the DUT period counter phase
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_line(input logic [3:0] chn, input logic [7:0] t, input logic [7:0] c);
`ifdef STAT_REPORT_ERR_EN
        logic [7:0] e;
        e = t - c;
`endif
        exp_q.push_back(8'h43);
        exp_q.push_back(hx(chn));
        exp_q.push_back(8'h3A);
        exp_q.push_back(hx(t[7:4]));
        exp_q.push_back(hx(t[3:0]));
        exp_q.push_back(8'h20);
        exp_q.push_back(hx(c[7:4]));
        exp_q.push_back(hx(c[3:0]));
`ifdef STAT_REPORT_ERR_EN
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h45);
        exp_q.push_back(hx(e[7:4]));
        exp_q.push_back(hx(e[3:0]));
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Advance to 2 time units after the edge that makes cyc == k
    task automatic at(input int k);
        int g;
        g = 0;
        do begin
            @(posedge clk);
            #2;
            g++;
        end while (cyc != k && g < 3000);
        if (cyc != k) chk("at_timeout", 64'(cyc), 64'(k));
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        #2;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare every transferred byte, and data stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold_stable", {55'd0, valid, data}, {55'd0, 1'b1, hold_d});
            if (valid && require) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h required none (cyc %0d)", data, cyc);
                end else begin
                    ev = exp_q.pop_front();
                    chk("byte", 64'(data), 64'(ev));
                    last_cyc = cyc;
                end
            end
            hold_v = valid && !require;
            hold_d = data;
        end
    end

    initial begin
        logic bad;
        errors   = 0;
        checks   = 0;
        last_cyc = -1;
        hold_v   = 1'b0;
        rst      = 1'b1;
        require  = 1'b1;
        total    = '0;
        correct  = '0;
        ch_en    = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Single channel, back-to-back
        ch_en   = 2'b01;
        total   = {8'h00, 8'h3A};
        correct = {8'h00, 8'h39};
        push_line(4'd0, 8'h3A, 8'h39);
        rst = 1'b0;
        at(99);
        chk("t1_pre_valid", 64'(valid), 64'd0);
        at(100);
        chk("t1_first_valid", 64'(valid), 64'd1);
        chk("t1_first_data", 64'(data), 64'h43);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_drain("t1_drain");
        chk("t1_last_cyc", 64'(last_cyc), 64'(100 + L - 1));

        // Channel 1 with require toggling
        at(190);
        ch_en   = 2'b10;
        total   = {8'hFF, 8'h00};
        correct = {8'h00, 8'h00};
        push_line(4'd1, 8'hFF, 8'h00);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            require = ~require;
        end
        require = 1'b1;
        wait_drain("t2_drain");

        // Two channels, inputs disturbed mid-frame
        at(290);
        ch_en   = 2'b11;
        total   = {8'h12, 8'hAB};
        correct = {8'h34, 8'hCD};
        push_line(4'd0, 8'hAB, 8'hCD);
        push_line(4'd1, 8'h12, 8'h34);
        at(305);
        total   = 16'hFFFF;
        correct = 16'hEEEE;
        ch_en   = 2'b00;
        wait_drain("t3_drain");
        chk("t3_last_cyc", 64'(last_cyc), 64'(300 + 2 * L - 1));

        // No channels enabled over three periods
        bad = 1'b0;
        while (cyc < 649) begin
            @(posedge clk);
            #2;
            if (busy || valid) bad = 1'b1;
        end
        chk("t4_idle", 64'(bad), 64'd0);

        // Tick on the same edge as the final LF
        at(650);
        ch_en   = 2'b01;
        total   = {8'h00, 8'hC3};
        correct = {8'h00, 8'h3C};
        push_line(4'd0, 8'hC3, 8'h3C);
        at(700 + L - 1);
        require = 1'b0;
        at(750);
        ch_en = 2'b00;
        at(799);
        chk("t5_busy_pre", 64'(busy), 64'd1);
        chk("t5_ovr_pre", 64'(overrun), 64'd0);
        require = 1'b1;
        at(801);
        chk("t5_ovr_post", 64'(overrun), 64'd1);
        chk("t5_busy_post", 64'(busy), 64'd0);
        chk("t5_drain", 64'(exp_q.size()), 64'd0);
        chk("t5_last_cyc", 64'(last_cyc), 64'd799);

        // Reset mid-frame, then error field check on the next frame
        at(850);
        ch_en   = 2'b01;
        total   = {8'h00, 8'h05};
        correct = {8'h00, 8'h07};
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h3A);
        at(903);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_ovr", 64'(overrun), 64'd0);
        chk("t6_rst_data", 64'(data), 64'd0);
        chk("t6_partial", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        push_line(4'd0, 8'h05, 8'h07);
        at(99);
        chk("t6_pre_valid", 64'(valid), 64'd0);
        at(100);
        chk("t6_first_valid", 64'(valid), 64'd1);
        wait_drain("t6_drain");

        // Long stall across a tick
        at(150);
        total   = {8'h00, 8'h5A};
        correct = {8'h00, 8'hA5};
        push_line(4'd0, 8'h5A, 8'hA5);
        at(203);
        require = 1'b0;
        at(299);
        chk("t7_ovr_pre", 64'(overrun), 64'd0);
        at(301);
        chk("t7_ovr_post", 64'(overrun), 64'd1);
        chk("t7_busy", 64'(busy), 64'd1);
        at(353);
        require = 1'b1;
        at(360);
        ch_en = 2'b00;
        wait_drain("t7_drain");
        at(450);
        chk("t7_ovr_sticky", 64'(overrun), 64'd1);
        chk("t7_busy_end", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
